// File: rtl/rr_stream_mux_if.sv
// Handshake bundle for rr_stream_mux: N valid/ready producer lanes in, one registered stream out.
// Signal suffixes are from the mux's point of view.
interface rr_stream_mux_if #(
    parameter int Width = 8,
    parameter int NumCh = 4
);
    localparam int SelW = $clog2(NumCh);

    logic [NumCh*Width-1:0] data_i;
    logic [NumCh-1:0]       valid_i;
    logic [NumCh-1:0]       ready_o;
    logic [Width-1:0]       data_o;
    logic                   valid_o;
    logic [SelW-1:0]        sel_o;
    logic                   ready_i;

    modport slave (
        input  data_i, valid_i, ready_i,
        output ready_o, data_o, valid_o, sel_o
    );

    modport master (
        output data_i, valid_i, ready_i,
        input  ready_o, data_o, valid_o, sel_o
    );
endinterface

// File: rtl/rr_stream_mux.sv
// N:1 stream mux with internal round-robin or fixed-priority arbitration and a
// single registered output stage that drains and reloads in the same cycle.
module rr_stream_mux #(
    parameter int Width      = 8,
    parameter int NumCh      = 4,
    parameter int RoundRobin = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    rr_stream_mux_if.slave     bus
);
    localparam int SelW = $clog2(NumCh);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q,  data_d;
    logic [SelW-1:0]  sel_q,   sel_d;
    logic [SelW-1:0]  ptr_q,   ptr_d;

    logic             ld;
    logic             grant_vld;
    logic [SelW-1:0]  grant_idx;
    logic [Width-1:0] grant_data;
    logic [NumCh-1:0] ready_vec;

    assign ld = !valid_q || bus.ready_i;

    // Two descending scans: the first finds the lowest requester overall (the
    // wrap-around candidate), the second overrides it with the lowest one at or
    // above the pointer, giving the first requester searching upward from ptr.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = NumCh-1; i >= 0; i--) begin
            if (bus.valid_i[i]) begin
                grant_vld = 1'b1;
                grant_idx = SelW'(i);
            end
        end
        if (RoundRobin != 0) begin
            for (int i = NumCh-1; i >= 0; i--) begin
                if (bus.valid_i[i] && (SelW'(i) >= ptr_q)) begin
                    grant_vld = 1'b1;
                    grant_idx = SelW'(i);
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NumCh; i++) begin
            if (SelW'(i) == grant_idx) begin
                grant_data = bus.data_i[i*Width +: Width];
            end
        end
    end

    // ready_o is gated by rst_ni so no producer sees an accept while in reset.
    always_comb begin
        ready_vec = '0;
        if (rst_ni && grant_vld && ld) begin
            for (int i = 0; i < NumCh; i++) begin
                ready_vec[i] = (SelW'(i) == grant_idx);
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (ld) begin
            if (grant_vld) begin
                valid_d = 1'b1;
                data_d  = grant_data;
                sel_d   = grant_idx;
                if (RoundRobin != 0) begin
                    ptr_d = (grant_idx == SelW'(NumCh-1)) ? '0 : grant_idx + 1'b1;
                end
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.ready_o = ready_vec;
    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;
    assign bus.sel_o   = sel_q;
endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: round-robin instance driven from a vector table,
// plus fixed-priority and 3-channel instances exercised with short hand sequences.
module tb_rr_stream_mux;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    rr_stream_mux_if #(.Width(8), .NumCh(4)) bus_a ();
    rr_stream_mux_if #(.Width(8), .NumCh(4)) bus_b ();
    rr_stream_mux_if #(.Width(8), .NumCh(3)) bus_c ();

    rr_stream_mux #(.Width(8), .NumCh(4), .RoundRobin(1)) dut_a (
        .clk_i (clk), .rst_ni (rst_n), .bus (bus_a.slave));
    rr_stream_mux #(.Width(8), .NumCh(4), .RoundRobin(0)) dut_b (
        .clk_i (clk), .rst_ni (rst_n), .bus (bus_b.slave));
    rr_stream_mux #(.Width(8), .NumCh(3), .RoundRobin(1)) dut_c (
        .clk_i (clk), .rst_ni (rst_n), .bus (bus_c.slave));

    typedef struct {
        logic [3:0] valid;
        logic       rdy;
        logic [3:0] exp_ready;
        logic       exp_vo;
        logic [1:0] exp_sel;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] c_sel [5];
    logic [7:0] c_dat [5];

    initial begin
        // valid, ready_i, expected ready_o (before edge), then valid_o/sel_o/data_o after edge
        vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h33};
        vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
        vecs[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
        vecs[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h22};
        vecs[7]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h22};
        vecs[8]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h22};
        vecs[9]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h22};
        vecs[10] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h22};
        vecs[11] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h33};
        vecs[12] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44};
        vecs[13] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
        vecs[14] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44};
        vecs[15] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
        vecs[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h11};
        vecs[17] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h11};
        vecs[18] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 8'h33};
        vecs[19] = '{4'b0010, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h33};
        vecs[20] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
        vecs[21] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
        vecs[22] = '{4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};

        c_sel = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1};
        c_dat = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22};

        bus_a.data_i  = 32'h44332211;
        bus_a.valid_i = 4'b1111;
        bus_a.ready_i = 1'b1;
        bus_b.data_i  = 32'h44332211;
        bus_b.valid_i = 4'b0000;
        bus_b.ready_i = 1'b1;
        bus_c.data_i  = 24'h332211;
        bus_c.valid_i = 3'b000;
        bus_c.ready_i = 1'b1;

        // Reset held with every channel requesting
        step();
        step();
        chk("rst_valid_o", 32'(bus_a.valid_o), 32'd0);
        chk("rst_data_o",  32'(bus_a.data_o),  32'd0);
        chk("rst_sel_o",   32'(bus_a.sel_o),   32'd0);
        chk("rst_ready_o", 32'(bus_a.ready_o), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready_o", 32'(bus_a.ready_o), 32'b0001);
        step();
        chk("rel_valid_o", 32'(bus_a.valid_o), 32'd1);
        chk("rel_sel_o",   32'(bus_a.sel_o),   32'd0);
        chk("rel_data_o",  32'(bus_a.data_o),  32'h11);

        // Asynchronous reset between edges while a word is held
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid_o", 32'(bus_a.valid_o), 32'd0);
        chk("async_ready_o", 32'(bus_a.ready_o), 32'd0);
        bus_a.valid_i = 4'b0000;
        step();
        rst_n = 1'b1;

        // Table: ptr starts at 0 after the reset above, so vector 0 must grant ch0
        for (int i = 0; i < 23; i++) begin
            bus_a.valid_i = vecs[i].valid;
            bus_a.ready_i = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d_ready_o", i), 32'(bus_a.ready_o), 32'(vecs[i].exp_ready));
            step();
            chk($sformatf("v%0d_valid_o", i), 32'(bus_a.valid_o), 32'(vecs[i].exp_vo));
            chk($sformatf("v%0d_sel_o", i),   32'(bus_a.sel_o),   32'(vecs[i].exp_sel));
            chk($sformatf("v%0d_data_o", i),  32'(bus_a.data_o),  32'(vecs[i].exp_data));
        end

        // Fixed priority: ch1 wins every cycle over ch2/ch3
        bus_b.valid_i = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("fp%0d_ready_o", i), 32'(bus_b.ready_o), 32'b0010);
            step();
            chk($sformatf("fp%0d_sel_o", i),   32'(bus_b.sel_o),   32'd1);
            chk($sformatf("fp%0d_data_o", i),  32'(bus_b.data_o),  32'h22);
        end
        bus_b.valid_i = 4'b1000;
        #1;
        chk("fp_hi_ready_o", 32'(bus_b.ready_o), 32'b1000);
        step();
        chk("fp_hi_sel_o",   32'(bus_b.sel_o),   32'd3);
        chk("fp_hi_data_o",  32'(bus_b.data_o),  32'h44);

        // Three channels: round-robin wraps from 2 back to 0
        bus_c.valid_i = 3'b111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("c3_%0d_valid_o", i), 32'(bus_c.valid_o), 32'd1);
            chk($sformatf("c3_%0d_sel_o", i),   32'(bus_c.sel_o),   32'(c_sel[i]));
            chk($sformatf("c3_%0d_data_o", i),  32'(bus_c.data_o),  32'(c_dat[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N-input, 1-output stream multiplexer: successor to the 4:1 combinational mux.
- Selection is internal: round-robin or fixed-priority arbitration between requesting channels, not an external select.
- Each input and the output use a valid/ready handshake; the output is registered (one pipeline stage).
- Sits between several producers (e.g. per-channel datapaths) and one shared consumer, e.g. a UART TX or memory-write port.

Parameters:
- Width, 8, data bits per channel.
- NumCh, 4, number of input channels; legal range 2..16.
- RoundRobin, 1, 1 = round-robin arbitration; 0 = fixed priority (lowest index wins).
- SelW, $clog2(NumCh), width of channel index; derived, not overridden.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset, asynchronous assert, active-low.
- data_i  input  NumCh*Width  packed channel data; channel k occupies bits [k*Width +: Width].
- valid_i  input  NumCh  per-channel request/valid.
- ready_o  output  NumCh  per-channel accept; one-hot or zero.
- data_o  output  Width  registered output data.
- valid_o  output  1  output data valid.
- sel_o  output  SelW  index of the channel whose data is in data_o.
- ready_i  input  1  downstream accept.

Behaviour:
- Reset (rst_ni=0, asynchronous): valid_o=0, data_o=0, sel_o=0, priority pointer=0. ready_o is forced to all-zero while rst_ni=0.
- Load enable: ld = !valid_o || ready_i.
- Arbitration (combinational, every cycle):
  - RoundRobin=1: search valid_i starting at index ptr, upward, wrapping NumCh-1 -> 0; the first set bit is grant g.
  - RoundRobin=0: g = lowest set index of valid_i.
  - If no valid_i is set, there is no grant.
- Handshakes:
  - ready_o[g] = ld when a grant exists; all other ready_o bits are 0.
  - An input transfer occurs when valid_i[k] && ready_o[k].
  - ready_o may depend combinationally on ready_i and valid_i; valid_i must not depend on ready_o.
- Output register, on a clock edge with ld=1:
  - If a grant exists: data_o <= data_i[g], sel_o <= g, valid_o <= 1.
  - Otherwise: valid_o <= 0; data_o and sel_o hold.
- Latency: an accepted input appears on data_o/valid_o the next cycle. Throughput is one transfer per cycle while ready_i=1.
- Back-pressure: while valid_o=1 and ready_i=0, data_o/sel_o/valid_o hold stable, all ready_o=0, and the pointer holds.
- Simultaneous drain and load: with valid_o=1, ready_i=1 and a grant, the output is replaced in the same edge with no bubble.
- Pointer update (RoundRobin=1 only): on an input transfer from g, ptr <= (g == NumCh-1) ? 0 : g+1. It is unchanged when there is no transfer. With RoundRobin=0 the pointer is unused and remains 0.
- Fairness: with all channels continuously valid and ready_i=1, grants cycle 0,1,...,NumCh-1,0,...
- A channel that drops valid_i before being granted loses nothing; no request is latched.
- Reset mid-operation: any in-flight output word is discarded, valid_o drops immediately (asynchronously), and the pointer returns to 0.
- Non-power-of-two NumCh: indices >= NumCh are never granted. Wrap-around goes to 0, not 2^SelW.

Test Plan:
- Reset: hold rst_ni=0 with all valid_i=1 -> valid_o=0, data_o=0, sel_o=0, ready_o=0. Release rst_ni -> next edge valid_o=1, sel_o=0.
- Round-robin sweep: NumCh=4, Width=8, data_i bytes {0x44,0x33,0x22,0x11}, all valid, ready_i=1 -> data_o sequence 0x11,0x22,0x33,0x44,0x11 and sel_o 0,1,2,3,0 on consecutive cycles.
- Sparse round-robin with wrap: valid_i=4'b1001, ptr=1 after reset plus one ch0 transfer -> next grant ch3 (sel_o=3), then ch0, alternating.
- Back-pressure: valid_o=1, data_o=0x22; hold ready_i=0 for 5 cycles -> data_o stays 0x22, ready_o=0000. Raise ready_i -> next word loads on the same edge, no bubble.
- Fixed priority: RoundRobin=0, valid_i=4'b1110 constant, ready_i=1 -> sel_o=1 every cycle; ch2 and ch3 are never granted.
- Async reset mid-stream: assert rst_ni low between edges while valid_o=1 -> valid_o=0 immediately, before the next edge. After release, the first grant uses ptr=0.
